x_result_writer: RTL and testbench

X_RESULT_WRITER -- requirements
Module: x_result_writer

---
 rtl/gsim_pkg.sv | 23 ++
 rtl/x_fifo.sv | 70 +++++++
 rtl/x_result_writer.sv | 167 ++++++++++++++++
 tb/tb_x_result_writer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// Shared widths, FIFO depth default, state encoding and the buffered word layout
// for the solver result writer.
package gsim_pkg;

    localparam int X_ADDR_W       = 9;
    localparam int X_DATA_W       = 32;
    localparam int MAT_W          = 5;
    localparam int COL_W          = 4;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int X_WORD_W       = X_ADDR_W + X_DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wr_state_e;

    typedef struct packed {
        logic [X_ADDR_W-1:0] addr;
        logic [X_DATA_W-1:0] data;
    } x_word_t;

endpackage

// File: rtl/x_fifo.sv
// Synchronous FIFO with flush and a registered head word; full/empty come from
// read/write pointers carrying one extra wrap bit.
module x_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 41
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_din,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [W-1:0] head_q, head_d;

    // The head register is loaded from the post-update memory image, so a word
    // written into an empty FIFO is visible on the very next cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            head_d   = '0;
        end else begin
            if (i_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = i_din;
                wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
            end
            if (i_pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
            head_d = mem_d[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            mem_q    <= mem_d;
        end
    end

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_head  = head_q;

endmodule

// File: rtl/x_result_writer.sv
// Buffers solver x results and drains them to result memory, tracking matrix
// completion, sticky overflow and address-sequence errors.
module x_result_writer
    import gsim_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_module_en,
    input  logic [MAT_W-1:0]    i_matrix_num,
    input  logic                i_x_wen,
    input  logic [X_ADDR_W-1:0] i_x_addr,
    input  logic [X_DATA_W-1:0] i_x_data,
    output logic                o_wr_req,
    output logic [X_ADDR_W-1:0] o_wr_addr,
    output logic [X_DATA_W-1:0] o_wr_data,
    input  logic                i_wr_ack,
    output logic                o_mat_done,
    output logic [MAT_W-1:0]    o_mat_idx,
    output logic                o_all_done,
    output logic                o_overflow,
    output logic                o_seq_err
);

    wr_state_e           state_q, state_d;
    logic                seen_low_q, seen_low_d;
    logic [X_ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [MAT_W-1:0]    mat_q, mat_d;
    logic                mat_done_q, mat_done_d;
    logic [MAT_W-1:0]    mat_idx_q, mat_idx_d;
    logic                all_done_q, all_done_d;
    logic                overflow_q, overflow_d;
    logic                seq_err_q, seq_err_d;

    logic    running, start, wr_req, push, pop, drop, flush;
    logic    fifo_full, fifo_empty;
    x_word_t push_word, head_word;

    // A job only starts after enable has been seen low, so a reset released
    // with enable still high does not resume the interrupted job.
    always_comb begin
        running        = (state_q == ST_RUN) && i_module_en;
        start          = (state_q == ST_IDLE) && i_module_en && seen_low_q;
        wr_req         = (state_q == ST_RUN) && !fifo_empty;
        pop            = wr_req && i_wr_ack;
        push           = running && i_x_wen && (!fifo_full || pop);
        drop           = running && i_x_wen && fifo_full && !pop;
        flush          = !i_module_en;
        push_word.addr = i_x_addr;
        push_word.data = i_x_data;
    end

    always_comb begin
        state_d    = state_q;
        seen_low_d = seen_low_q | ~i_module_en;
        exp_addr_d = exp_addr_q;
        col_d      = col_q;
        mat_d      = mat_q;
        mat_done_d = 1'b0;
        mat_idx_d  = '0;
        overflow_d = overflow_q;
        seq_err_d  = seq_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    exp_addr_d = '0;
                    col_d      = '0;
                    mat_d      = '0;
                    overflow_d = 1'b0;
                    seq_err_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if ((mat_q == i_matrix_num) && fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase

        if (running) begin
            if (push) begin
                exp_addr_d = exp_addr_q + X_ADDR_W'(1);
                if (i_x_addr != exp_addr_q) begin
                    seq_err_d = 1'b1;
                end
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
            if (pop) begin
                col_d = col_q + COL_W'(1);
                if (col_q == {COL_W{1'b1}}) begin
                    mat_done_d = 1'b1;
                    mat_idx_d  = mat_q;
                    mat_d      = mat_q + MAT_W'(1);
                end
            end
        end

        // Enable low aborts from any state; sticky flags survive until the next start.
        if (!i_module_en) begin
            state_d    = ST_IDLE;
            exp_addr_d = '0;
            col_d      = '0;
            mat_d      = '0;
        end

        all_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            seen_low_q <= 1'b0;
            exp_addr_q <= '0;
            col_q      <= '0;
            mat_q      <= '0;
            mat_done_q <= 1'b0;
            mat_idx_q  <= '0;
            all_done_q <= 1'b0;
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            seen_low_q <= seen_low_d;
            exp_addr_q <= exp_addr_d;
            col_q      <= col_d;
            mat_q      <= mat_d;
            mat_done_q <= mat_done_d;
            mat_idx_q  <= mat_idx_d;
            all_done_q <= all_done_d;
            overflow_q <= overflow_d;
            seq_err_q  <= seq_err_d;
        end
    end

    x_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (X_WORD_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (flush),
        .i_din   (push_word),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_head  (head_word)
    );

    assign o_wr_req   = wr_req;
    assign o_wr_addr  = head_word.addr;
    assign o_wr_data  = head_word.data;
    assign o_mat_done = mat_done_q;
    assign o_mat_idx  = mat_idx_q;
    assign o_all_done = all_done_q;
    assign o_overflow = overflow_q;
    assign o_seq_err  = seq_err_q;

endmodule

// File: tb/tb_x_result_writer.sv
// Bench for x_result_writer: a queue-based reference model checked every cycle,
// directed job scenarios with literal expectations, then randomized jobs.
module tb_x_result_writer;

    localparam int DEPTH  = 8;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_module_en = 1'b0;
    logic [4:0]  i_matrix_num = '0;
    logic        i_x_wen = 1'b0;
    logic [8:0]  i_x_addr = '0;
    logic [31:0] i_x_data = '0;
    logic        i_wr_ack = 1'b0;
    logic        o_wr_req;
    logic [8:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_mat_done;
    logic [4:0]  o_mat_idx;
    logic        o_all_done;
    logic        o_overflow;
    logic        o_seq_err;

    int n_checks = 0;
    int n_errors = 0;

    int          m_state = M_IDLE;
    bit          m_seen_low = 1'b0;
    int          m_exp = 0;
    int          m_col = 0;
    int          m_mat = 0;
    bit          m_ovf = 1'b0;
    bit          m_seq = 1'b0;
    bit          m_done_pulse = 1'b0;
    int          m_done_idx = 0;
    logic [40:0] m_q[$];

    logic [8:0]  wlog_addr[$];
    logic [31:0] wlog_data[$];
    int          done_cnt = 0;
    logic [4:0]  last_idx = '0;

    x_result_writer #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_module_en  (i_module_en),
        .i_matrix_num (i_matrix_num),
        .i_x_wen      (i_x_wen),
        .i_x_addr     (i_x_addr),
        .i_x_data     (i_x_data),
        .o_wr_req     (o_wr_req),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .i_wr_ack     (i_wr_ack),
        .o_mat_done   (o_mat_done),
        .o_mat_idx    (o_mat_idx),
        .o_all_done   (o_all_done),
        .o_overflow   (o_overflow),
        .o_seq_err    (o_seq_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit wen, input logic [8:0] addr,
                                 input logic [31:0] data, input bit ack);
        i_module_en = en;
        i_x_wen     = wen;
        i_x_addr    = addr;
        i_x_data    = data;
        i_wr_ack    = ack;
        @(posedge i_clk);
        #2;
    endtask

    task automatic startJob(input logic [4:0] n);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        i_matrix_num = n;
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
        wlog_addr.delete();
        wlog_data.delete();
        done_cnt = 0;
    endtask

    // Reference model: the FIFO is a plain queue, counters are integers.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_state = M_IDLE;
            m_seen_low = 1'b0;
            m_exp = 0;
            m_col = 0;
            m_mat = 0;
            m_ovf = 1'b0;
            m_seq = 1'b0;
            m_done_pulse = 1'b0;
            m_done_idx = 0;
            m_q.delete();
        end else begin
            bit req, pop, full, done_cond;
            req = (m_state == M_RUN) && (m_q.size() != 0);
            pop = req && i_wr_ack;
            m_done_pulse = 1'b0;
            if (!i_module_en) begin
                m_state = M_IDLE;
                m_q.delete();
                m_exp = 0;
                m_col = 0;
                m_mat = 0;
                m_seen_low = 1'b1;
            end else if (m_state == M_IDLE) begin
                if (m_seen_low) begin
                    m_state = M_RUN;
                    m_exp = 0;
                    m_col = 0;
                    m_mat = 0;
                    m_ovf = 1'b0;
                    m_seq = 1'b0;
                end
            end else if (m_state == M_RUN) begin
                full = (m_q.size() == DEPTH);
                done_cond = (m_mat == int'(i_matrix_num)) && (m_q.size() == 0);
                if (pop) begin
                    void'(m_q.pop_front());
                    m_col = (m_col + 1) % 16;
                    if (m_col == 0) begin
                        m_done_pulse = 1'b1;
                        m_done_idx = m_mat;
                        m_mat = (m_mat + 1) % 32;
                    end
                end
                if (i_x_wen) begin
                    if (!full || pop) begin
                        m_q.push_back({i_x_addr, i_x_data});
                        if (int'(i_x_addr) != m_exp) m_seq = 1'b1;
                        m_exp = (m_exp + 1) % 512;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (done_cond) m_state = M_DONE;
            end
        end
    end

    always @(negedge i_clk) begin
        bit req;
        req = (m_state == M_RUN) && (m_q.size() != 0);
        checkOutput("wr_req", 64'(o_wr_req), 64'(req));
        if (req) begin
            checkOutput("wr_addr", 64'(o_wr_addr), 64'(m_q[0][40:32]));
            checkOutput("wr_data", 64'(o_wr_data), 64'(m_q[0][31:0]));
        end
        checkOutput("all_done", 64'(o_all_done), 64'(m_state == M_DONE));
        checkOutput("overflow", 64'(o_overflow), 64'(m_ovf));
        checkOutput("seq_err", 64'(o_seq_err), 64'(m_seq));
        checkOutput("mat_done", 64'(o_mat_done), 64'(m_done_pulse));
        if (m_done_pulse) checkOutput("mat_idx", 64'(o_mat_idx), 64'(m_done_idx));
    end

    always @(negedge i_clk) begin
        if (o_wr_req && i_wr_ack) begin
            wlog_addr.push_back(o_wr_addr);
            wlog_data.push_back(o_wr_data);
        end
        if (o_mat_done) begin
            done_cnt++;
            last_idx = o_mat_idx;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] s1_data [16];
        logic [31:0] first_data;
        int          wsize;
        int          words, k, cycles;
        bit          wen;
        logic [8:0]  addr;

        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("reset_wr_req", 64'(o_wr_req), 64'd0);
        checkOutput("reset_all_done", 64'(o_all_done), 64'd0);
        checkOutput("reset_wr_addr", 64'(o_wr_addr), 64'd0);
        #1;
        i_rst_n = 1'b1;

        // One matrix, every second cycle, memory always ready.
        startJob(5'd1);
        for (int i = 0; i < 16; i++) begin
            s1_data[i] = $urandom;
            applyStimulus(1'b1, 1'b1, 9'(i), s1_data[i], 1'b1);
            applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
        end
        repeat (4) applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
        checkOutput("s1_write_count", 64'(wlog_addr.size()), 64'd16);
        for (int i = 0; i < 16 && i < wlog_addr.size(); i++) begin
            checkOutput("s1_addr", 64'(wlog_addr[i]), 64'(i));
            checkOutput("s1_data", 64'(wlog_data[i]), 64'(s1_data[i]));
        end
        checkOutput("s1_done_pulses", 64'(done_cnt), 64'd1);
        checkOutput("s1_done_idx", 64'(last_idx), 64'd0);
        checkOutput("s1_all_done", 64'(o_all_done), 64'd1);
        checkOutput("s1_overflow", 64'(o_overflow), 64'd0);
        checkOutput("s1_seq_err", 64'(o_seq_err), 64'd0);

        // Two matrices with memory stalled for the first 20 cycles.
        startJob(5'd2);
        first_data = 32'hCAFE_0000;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b1, 9'(i), (i == 0) ? first_data : $urandom, i >= 20);
            if (i == 7) checkOutput("s2_no_overflow_at_8", 64'(o_overflow), 64'd0);
            if (i == 8) checkOutput("s2_overflow_at_9", 64'(o_overflow), 64'd1);
            if (i == 15) begin
                checkOutput("s2_hold_addr", 64'(o_wr_addr), 64'd0);
                checkOutput("s2_hold_data", 64'(o_wr_data), 64'(first_data));
            end
        end
        repeat (12) applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
        checkOutput("s2_all_done", 64'(o_all_done), 64'd0);

        // Address sequence break.
        startJob(5'd1);
        applyStimulus(1'b1, 1'b1, 9'd0, 32'h11, 1'b1);
        applyStimulus(1'b1, 1'b1, 9'd1, 32'h22, 1'b1);
        checkOutput("s3_seq_before", 64'(o_seq_err), 64'd0);
        applyStimulus(1'b1, 1'b1, 9'd3, 32'h33, 1'b1);
        checkOutput("s3_seq_after", 64'(o_seq_err), 64'd1);
        repeat (3) applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
        checkOutput("s3_count", 64'(wlog_addr.size()), 64'd3);
        if (wlog_addr.size() == 3) begin
            checkOutput("s3_addr0", 64'(wlog_addr[0]), 64'd0);
            checkOutput("s3_addr1", 64'(wlog_addr[1]), 64'd1);
            checkOutput("s3_addr2", 64'(wlog_addr[2]), 64'd3);
        end

        // Full FIFO with push and ack together, then a push without ack.
        startJob(5'd1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 9'(i), $urandom, 1'b0);
        checkOutput("s4_full_no_ovf", 64'(o_overflow), 64'd0);
        applyStimulus(1'b1, 1'b1, 9'd8, $urandom, 1'b1);
        checkOutput("s4_push_pop_no_ovf", 64'(o_overflow), 64'd0);
        applyStimulus(1'b1, 1'b1, 9'd9, $urandom, 1'b0);
        checkOutput("s4_still_full_ovf", 64'(o_overflow), 64'd1);
        repeat (10) applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
        checkOutput("s4_count", 64'(wlog_addr.size()), 64'd9);
        if (wlog_addr.size() == 9) checkOutput("s4_last_addr", 64'(wlog_addr[8]), 64'd8);

        // Abort with words buffered, then an empty job.
        startJob(5'd1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 9'(i), $urandom, 1'b0);
        checkOutput("s5_req_before_abort", 64'(o_wr_req), 64'd1);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("s5_req_after_abort", 64'(o_wr_req), 64'd0);
        i_matrix_num = 5'd0;
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
        checkOutput("s5_all_done_1cyc", 64'(o_all_done), 64'd0);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
        checkOutput("s5_all_done_2cyc", 64'(o_all_done), 64'd1);

        // Asynchronous reset in the middle of a drain.
        startJob(5'd1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 9'(i), $urandom, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
        #1;
        i_rst_n = 1'b0;
        #1;
        checkOutput("s6_rst_wr_req", 64'(o_wr_req), 64'd0);
        checkOutput("s6_rst_wr_addr", 64'(o_wr_addr), 64'd0);
        checkOutput("s6_rst_wr_data", 64'(o_wr_data), 64'd0);
        checkOutput("s6_rst_mat_done", 64'(o_mat_done), 64'd0);
        checkOutput("s6_rst_mat_idx", 64'(o_mat_idx), 64'd0);
        checkOutput("s6_rst_all_done", 64'(o_all_done), 64'd0);
        checkOutput("s6_rst_overflow", 64'(o_overflow), 64'd0);
        checkOutput("s6_rst_seq_err", 64'(o_seq_err), 64'd0);
        @(posedge i_clk);
        #4;
        i_rst_n = 1'b1;
        wsize = wlog_addr.size();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 9'(i), $urandom, 1'b1);
        checkOutput("s6_no_resume_writes", 64'(wlog_addr.size()), 64'(wsize));
        checkOutput("s6_no_resume_req", 64'(o_wr_req), 64'd0);
        startJob(5'd0);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
        checkOutput("s6_restart_done", 64'(o_all_done), 64'd1);

        // Randomized jobs checked by the model alone.
        for (int job = 0; job < 8; job++) begin
            startJob(5'($urandom_range(0, 2)));
            words  = int'(i_matrix_num) * 16 + int'($urandom_range(0, 2));
            cycles = words * 3 + 20;
            k = 0;
            for (int c = 0; c < cycles; c++) begin
                wen  = (k < words) && ($urandom_range(0, 1) == 1);
                addr = ($urandom_range(0, 19) == 0) ? 9'($urandom) : 9'(k);
                if ($urandom_range(0, 299) == 0) begin
                    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
                    break;
                end
                applyStimulus(1'b1, wen, addr, $urandom, $urandom_range(0, 99) < 60);
                if (wen) k++;
            end
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
